// File: rtl/tx_snap_capture_ctrl.sv
// tx_snap_capture_ctrl
// Arms and triggers a snapshot capture of the 10GbE TX data stream into a
// BRAM. The software control word is registered once, an arm rising edge
// starts a capture (immediately or after an external trigger), and every
// qualifying cycle produces one registered BRAM write. A status word reports
// done, busy and the number of words written.
module tx_snap_capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_we,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Count value after the final write, and the count of the final write.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam int              PAD_W    = 29 - ADDR_W;

  // Registered control bits: [0] arm, [1] trig_sel, [2] we_sel, [3] abort.
  logic [3:0]        ctrl_q;
  logic              arm_prev_q;

  state_t            state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [ADDR_W:0]   stat_cnt_q;
  logic              done_q;
  logic              busy_q;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_din_q;

  logic              arm_s;
  logic              trig_sel_s;
  logic              we_sel_s;
  logic              abort_s;
  logic              arm_rise_s;
  logic              qual_s;
  logic              write_s;
  logic              last_s;
  logic              unused_ctrl_s;

  // Only the low four control bits carry meaning.
  assign unused_ctrl_s = ^ctrl[31:4];

  assign arm_s      = ctrl_q[0];
  assign trig_sel_s = ctrl_q[1];
  assign we_sel_s   = ctrl_q[2];
  assign abort_s    = ctrl_q[3];

  // An arm edge is only honoured while abort is low.
  assign arm_rise_s = arm_s & ~arm_prev_q & ~abort_s;
  assign qual_s     = we_sel_s | din_we;
  assign last_s     = (count_q == LAST_CNT);
  assign count_d    = count_q + {{ADDR_W{1'b0}}, 1'b1};

  // A write is issued in CAPTURE, or in WAIT_TRIG on the trigger cycle itself.
  assign write_s = ~abort_s & qual_s & (count_q != FULL_CNT) &
                   ((state_q == ST_CAPTURE) | ((state_q == ST_WAIT_TRIG) & trig));

  // Control word register and arm-edge history. The arm bit and its history
  // both come out of reset high, so an arm level already present at reset
  // release is not seen as a new edge.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q     <= 4'b0001;
      arm_prev_q <= 1'b1;
    end else begin
      ctrl_q     <= ctrl[3:0];
      arm_prev_q <= ctrl_q[0];
    end
  end

  // Capture FSM together with the registered BRAM port and status fields.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= {(ADDR_W+1){1'b0}};
      stat_cnt_q  <= {(ADDR_W+1){1'b0}};
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= {ADDR_W{1'b0}};
      bram_din_q  <= {DATA_W{1'b0}};
    end else begin
      bram_we_q   <= write_s;
      // Address tracks the count, so it holds the write address during the
      // write strobe and wraps to zero once the count reaches full depth.
      bram_addr_q <= count_q[ADDR_W-1:0];
      stat_cnt_q  <= count_q;
      if (write_s) begin
        bram_din_q <= din;
        count_q    <= count_d;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (arm_rise_s) begin
            state_q <= trig_sel_s ? ST_WAIT_TRIG : ST_CAPTURE;
            count_q <= {(ADDR_W+1){1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT_TRIG, ST_CAPTURE: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (write_s && last_s) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if ((state_q == ST_WAIT_TRIG) && trig) begin
            state_q <= ST_CAPTURE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign status    = {done_q, busy_q, {PAD_W{1'b0}}, stat_cnt_q};

endmodule

// File: tb/tb_tx_snap_capture_ctrl.sv
// Self-checking bench for tx_snap_capture_ctrl (ADDR_W = 4).
// A behavioural capture model predicts, per clock, whether a BRAM write must
// appear next cycle (with its address and data) and what the status word shows.
module tb_tx_snap_capture_ctrl;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int DEPTH = 16;

  logic          user_clk;
  logic          user_rst_n;
  logic [31:0]   ctrl;
  logic [DW-1:0] din;
  logic          din_we;
  logic          trig;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic [31:0]   status;

  tx_snap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .ctrl      (ctrl),
    .din       (din),
    .din_we    (din_we),
    .trig      (trig),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .status    (status)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  typedef enum int {M_IDLE, M_WAIT, M_CAP, M_DONE} mmode_t;
  mmode_t        m_mode;
  int            m_count;
  logic [3:0]    m_ctrl_q;
  logic          m_arm_prev;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            exp_cnt_status;

  // Observation bookkeeping per scenario.
  int            we_cnt;
  logic          first_seen;
  logic [AW-1:0] first_addr;
  logic [DW-1:0] first_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode         = M_IDLE;
    m_count        = 0;
    m_ctrl_q       = 4'b0001;
    m_arm_prev     = 1'b1;
    exp_we         = 1'b0;
    exp_cnt_status = 0;
  endtask

  // Apply the capture rules to the inputs present just before a clock edge.
  task automatic model_edge();
    logic rise;
    logic abort;
    logic qual;
    logic wr;
    rise  = m_ctrl_q[0] && !m_arm_prev && !m_ctrl_q[3];
    abort = m_ctrl_q[3];
    qual  = m_ctrl_q[2] || din_we;
    exp_cnt_status = m_count;
    wr = !abort && qual && (m_mode == M_CAP || (m_mode == M_WAIT && trig));
    exp_we = wr;
    if (abort) begin
      m_mode = M_IDLE;
    end else if (wr) begin
      exp_addr = AW'(m_count);
      exp_data = din;
      m_count++;
      m_mode = (m_count == DEPTH) ? M_DONE : M_CAP;
    end else if ((m_mode == M_IDLE || m_mode == M_DONE) && rise) begin
      m_mode  = m_ctrl_q[1] ? M_WAIT : M_CAP;
      m_count = 0;
    end else if (m_mode == M_WAIT && trig) begin
      m_mode = M_CAP;
    end
    m_arm_prev = m_ctrl_q[0];
    m_ctrl_q   = ctrl[3:0];
  endtask

  task automatic check_outputs();
    logic ed;
    logic eb;
    ed = (m_mode == M_DONE);
    eb = (m_mode == M_WAIT) || (m_mode == M_CAP);
    chk("bram_we", 64'(bram_we), 64'(exp_we));
    if (bram_we) begin
      we_cnt++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_addr = bram_addr;
        first_data = bram_din;
      end
    end
    if (exp_we) begin
      chk("bram_addr", 64'(bram_addr), 64'(exp_addr));
      chk("bram_din", bram_din, exp_data);
    end
    chk("status", 64'(status), 64'({ed, eb, 25'd0, 5'(exp_cnt_status)}));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge user_clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      din = {$urandom, $urandom};
      cyc();
    end
  endtask

  task automatic new_scn();
    we_cnt     = 0;
    first_seen = 1'b0;
    first_addr = '0;
    first_data = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, 64'(bram_we), 64'd0);
    chk({tag, "_addr"}, 64'(bram_addr), 64'd0);
    chk({tag, "_din"}, bram_din, 64'd0);
    chk({tag, "_status"}, 64'(status), 64'd0);
  endtask

  // Assert reset asynchronously, check outputs at once, release away from the edge.
  task automatic do_reset(input logic [31:0] c);
    user_rst_n = 1'b0;
    ctrl   = c;
    din_we = 1'b0;
    trig   = 1'b0;
    din    = '0;
    #2;
    check_reset_vals("rst_async");
    repeat (2) @(posedge user_clk);
    #1;
    check_reset_vals("rst_hold");
    user_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    user_rst_n = 1'b1;
    ctrl = 32'd0; din = '0; din_we = 1'b0; trig = 1'b0;
    new_scn();
    model_reset();
    #3;
    do_reset(32'd0);
    run(2);

    // 1: immediate, write-always capture of a ramp.
    new_scn();
    ctrl = 32'h4; cyc();
    ctrl = 32'h5;
    for (int i = 0; i < 25; i++) begin
      din = 64'h100 + 64'(m_count);
      cyc();
    end
    chk("s1_pulses", 64'(we_cnt), 64'd16);
    chk("s1_status", 64'(status), 64'h8000_0010);
    chk("s1_addr_wrap", 64'(bram_addr), 64'd0);
    chk("s1_first_data", first_data, 64'h100);

    // 2: din_we high every third cycle.
    new_scn();
    ctrl = 32'h0; cyc(); cyc();
    ctrl = 32'h1;
    for (int i = 0; i < 70; i++) begin
      din    = {$urandom, $urandom};
      din_we = (i % 3 == 0);
      cyc();
    end
    chk("s2_pulses", 64'(we_cnt), 64'd16);
    chk("s2_status", 64'(status), 64'h8000_0010);

    // 3: triggered capture; nothing written while waiting.
    new_scn();
    din_we = 1'b1;
    ctrl = 32'h0; cyc(); cyc();
    ctrl = 32'h3;
    run(40);
    chk("s3_busy_wait", 64'(status[30]), 64'd1);
    chk("s3_no_early_we", 64'(we_cnt), 64'd0);
    trig = 1'b1; din = 64'hAA; cyc();
    trig = 1'b0;
    run(30);
    chk("s3_first_addr", 64'(first_addr), 64'd0);
    chk("s3_first_data", first_data, 64'hAA);
    chk("s3_status", 64'(status), 64'h8000_0010);

    // 4: abort after five writes, then rearm.
    new_scn();
    ctrl = 32'h0; cyc();
    ctrl = 32'h5; cyc(); cyc();
    for (int i = 0; i < 40 && m_count < 4; i++) run(1);
    ctrl = 32'hD;
    run(12);
    chk("s4_abort_status", 64'(status), 64'h0000_0005);
    chk("s4_abort_pulses", 64'(we_cnt), 64'd5);
    new_scn();
    ctrl = 32'h4; cyc();
    ctrl = 32'h5;
    run(25);
    chk("s4_restart_addr", 64'(first_addr), 64'd0);
    chk("s4_restart_status", 64'(status), 64'h8000_0010);

    // 5: arm already high at reset release starts nothing.
    new_scn();
    do_reset(32'h1);
    run(10);
    chk("s5_no_capture", 64'(we_cnt), 64'd0);
    chk("s5_status_idle", 64'(status), 64'd0);
    ctrl = 32'h0; cyc(); cyc();
    ctrl = 32'h1; din_we = 1'b1;
    run(25);
    chk("s5_capture", 64'(status), 64'h8000_0010);

    // 6: arm re-toggle mid-capture is ignored; toggle in DONE restarts.
    new_scn();
    ctrl = 32'h4; cyc(); cyc();
    ctrl = 32'h5; run(8);
    ctrl = 32'h4; run(2);
    ctrl = 32'h5; run(20);
    chk("s6_pulses", 64'(we_cnt), 64'd16);
    chk("s6_status", 64'(status), 64'h8000_0010);
    ctrl = 32'h4; run(2);
    chk("s6_done_held", 64'(status[31]), 64'd1);
    ctrl = 32'h5; run(2);
    chk("s6_done_drop", 64'(status[31]), 64'd0);
    run(20);
    chk("s6_recapture", 64'(status), 64'h8000_0010);

    // 7: asynchronous reset in the middle of a capture.
    ctrl = 32'h4; cyc(); cyc();
    ctrl = 32'h5; run(6);
    do_reset(32'h5);
    new_scn();
    run(10);
    chk("s7_no_we_after_rst", 64'(we_cnt), 64'd0);

    // 8: randomized control, valid and trigger activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        ctrl = $urandom;
        if ($urandom_range(0, 3) != 0) ctrl[3] = 1'b0;
      end
      din_we = 1'($urandom_range(0, 1));
      trig   = ($urandom_range(0, 7) == 0);
      din    = {$urandom, $urandom};
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
